pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter WAIT_LIMIT, default 15, the maximum cycles a fetch waits for pm_ack before it is flagged (range 1-15).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock, no other clock/reset domains.
REQ-005 jmp_loc  input  16  jump target from jump-control block.
REQ-006 pc_mux_sel  input  1  1 = next PC is jmp_loc, 0 = next PC is PC+1.
REQ-007 stall  input  1  downstream not ready; holds the issued instruction.
REQ-008 pm_ack  input  1  program memory data valid this cycle.
REQ-009 pm_data  input  32  instruction word from program memory.
REQ-010 pm_req  output  1  fetch request to program memory.
REQ-011 pm_addr  output  16  fetch address (current PC).
REQ-012 ins_valid  output  1  issued instruction valid.
REQ-013 ins  output  32  issued instruction register.
REQ-014 op  output  6  ins[31:26], to jump-control block.
REQ-015 jmp_address_pm  output  16  ins[15:0], to jump-control block.
REQ-016 current_address  output  16  address of the issued instruction.
REQ-017 fetch_err  output  1  sticky: a fetch exceeded WAIT_LIMIT.

Function
REQ-018 SHALL implement a 2-state FSM, FETCH and ISSUE; the reset state is FETCH.
REQ-019 In FETCH: pm_req=1, pm_addr=PC, ins_valid=0; a 4-bit wait counter increments each cycle without pm_ack.
REQ-020 FETCH with pm_ack=1: ins<=pm_data, current_address<=PC, wait counter<=0, next state ISSUE (latency: ins_valid rises the cycle after pm_ack).
REQ-021 FETCH when the wait counter reaches WAIT_LIMIT with no pm_ack: fetch_err<=1, wait counter<=0, remain in FETCH re-requesting the same PC.
REQ-022 fetch_err SHALL remain 1 until reset.
REQ-023 In ISSUE: pm_req=0, ins_valid=1; ins, op, jmp_address_pm, current_address held stable.
REQ-024 ISSUE with stall=1: remain in ISSUE, PC unchanged; pc_mux_sel and jmp_loc ignored.
REQ-025 ISSUE with stall=0: PC<=jmp_loc if pc_mux_sel=1 else PC+1; next state FETCH.
REQ-026 PC+1 SHALL wrap 16'hFFFF to 16'h0000 with no flag.
REQ-027 pm_ack while in ISSUE SHALL be ignored (no IR update).
REQ-028 pc_mux_sel and jmp_loc SHALL be sampled only in the ISSUE-to-FETCH cycle.
REQ-029 op and jmp_address_pm SHALL be combinational slices of ins.
REQ-030 Minimum throughput: one instruction per 2 cycles (pm_ack in first FETCH cycle, stall=0).

Reset
REQ-031 On reset=1 at a clock edge: state<=FETCH, PC<=RESET_PC, ins<=0, current_address<=0, wait counter<=0, fetch_err<=0.
REQ-032 Reset SHALL take priority over pm_ack, stall and pc_mux_sel in the same cycle.
REQ-033 Reset asserted mid-fetch: pm_req stays 1 (FETCH) but pm_addr returns to RESET_PC the next cycle; a pm_ack coincident with reset SHALL be discarded.
REQ-034 While reset=1, outputs: pm_req=1, pm_addr=RESET_PC, ins_valid=0, ins=0, fetch_err=0.

Verification
REQ-035 Reset, pm_ack=1 every cycle with pm_data=32'h0400_0000+addr, stall=0, pc_mux_sel=0 -> pm_addr 0,1,2,... on alternate cycles; ins_valid toggles; current_address matches.
REQ-036 Issue at addr 3 with pm_data=32'h6000_0008 (op=6'h18), pc_mux_sel=1, jmp_loc=16'h0008 -> next pm_addr=16'h0008, current_address next issue=16'h0008.
REQ-037 stall=1 for 5 cycles in ISSUE -> ins, current_address, ins_valid=1 constant; PC advances once, on the cycle stall drops.
REQ-038 PC=16'hFFFF issued, stall=0, pc_mux_sel=0 -> next pm_addr=16'h0000.
REQ-039 pm_ack withheld 15 cycles -> fetch_err=1 on cycle 16, pm_addr unchanged; later pm_ack completes fetch; fetch_err stays 1 until reset.
REQ-040 reset pulsed during FETCH with coincident pm_ack -> ins=0, ins_valid=0, pm_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: program-memory request/response, jump control, issue outputs.
// Latency: wires only, no storage.
// Backpressure: stall from the consumer holds the issued instruction; pm_ack completes a fetch.
interface pc_fetch_unit_if;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic        stall;
    logic        pm_ack;
    logic [31:0] pm_data;
    logic        pm_req;
    logic [15:0] pm_addr;
    logic        ins_valid;
    logic [31:0] ins;
    logic [5:0]  op;
    logic [15:0] jmp_address_pm;
    logic [15:0] current_address;
    logic        fetch_err;

    // Fetch unit side
    modport slave (
        input  jmp_loc, pc_mux_sel, stall, pm_ack, pm_data,
        output pm_req, pm_addr, ins_valid, ins, op, jmp_address_pm, current_address, fetch_err
    );

    // Environment side (program memory, jump control, downstream consumer)
    modport master (
        output jmp_loc, pc_mux_sel, stall, pm_ack, pm_data,
        input  pm_req, pm_addr, ins_valid, ins, op, jmp_address_pm, current_address, fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: requests an instruction at PC, latches it on pm_ack, issues it, then advances PC.
// Latency: ins_valid rises the cycle after pm_ack; best case one instruction every 2 cycles.
// Backpressure: stall holds the issued instruction and PC; a fetch waiting too long sets sticky fetch_err.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          WAIT_LIMIT = 15
) (
    input logic            clk,
    input logic            reset,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Counter value at which the next ack-less cycle is the WAIT_LIMIT-th one.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [15:0] cur_q, cur_d;
    logic [3:0]  wait_q, wait_d;
    logic        err_q, err_d;

    // State register; reset wins over every other input in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ins_q   <= 32'h0000_0000;
            cur_q   <= 16'h0000;
            wait_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            cur_q   <= cur_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: latch on ack in FETCH, advance PC when ISSUE is released.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        cur_d   = cur_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            FETCH: begin
                if (bus.pm_ack) begin
                    ins_d   = bus.pm_data;
                    cur_d   = pc_q;
                    wait_d  = 4'd0;
                    state_d = ISSUE;
                end else if (wait_q == WAIT_LAST) begin
                    // Give up on this attempt, flag it, and keep requesting the same PC.
                    err_d  = 1'b1;
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ISSUE: begin
                // Jump inputs only matter on the cycle the instruction is accepted.
                if (!bus.stall) begin
                    pc_d    = bus.pc_mux_sel ? bus.jmp_loc : pc_q + 16'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.pm_req          = (state_q == FETCH);
    assign bus.pm_addr         = pc_q;
    assign bus.ins_valid       = (state_q == ISSUE);
    assign bus.ins             = ins_q;
    assign bus.op              = ins_q[31:26];
    assign bus.jmp_address_pm  = ins_q[15:0];
    assign bus.current_address = cur_q;
    assign bus.fetch_err       = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: samples outputs 1ns after each rising edge.
// Backpressure: stall, pm_ack and pc_mux_sel are driven by the bench.
module tb_pc_fetch_unit;

    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int          WAIT_LIMIT = 15;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(RESET_PC), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: which phase we are in, the PC, the held instruction, and how long the fetch has waited.
    logic        m_issue;
    logic [15:0] m_pc;
    logic [15:0] m_cur;
    logic [31:0] m_ins;
    logic        m_err;
    int          m_waited;

    task automatic drive(input logic ack, input logic [31:0] data, input logic stl,
                         input logic sel, input logic [15:0] jmp);
        bus.pm_ack     = ack;
        bus.pm_data    = data;
        bus.stall      = stl;
        bus.pc_mux_sel = sel;
        bus.jmp_loc    = jmp;
    endtask

    // Apply the rules to the inputs present now, then advance one clock.
    task automatic tick();
        if (reset) begin
            m_issue = 1'b0; m_pc = RESET_PC; m_ins = '0; m_cur = '0; m_err = 1'b0; m_waited = 0;
        end else if (!m_issue) begin
            if (bus.pm_ack) begin
                m_ins = bus.pm_data; m_cur = m_pc; m_issue = 1'b1; m_waited = 0;
            end else begin
                m_waited++;
                if (m_waited % WAIT_LIMIT == 0) m_err = 1'b1;
            end
        end else if (!bus.stall) begin
            m_pc     = bus.pc_mux_sel ? bus.jmp_loc : m_pc + 16'd1;
            m_issue  = 1'b0;
            m_waited = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 16'h1234);
        tick();
        n_total++; if (bus.pm_req !== 1'b1) begin n_bad++; $display("FAIL reset_pm_req: got %b want 1", bus.pm_req); end
        n_total++; if (bus.pm_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_pm_addr: got %h want %h", bus.pm_addr, RESET_PC); end
        n_total++; if (bus.ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ins_valid: got %b want 0", bus.ins_valid); end
        n_total++; if (bus.ins !== 32'h0) begin n_bad++; $display("FAIL reset_ins: got %h want 0", bus.ins); end
        n_total++; if (bus.current_address !== 16'h0) begin n_bad++; $display("FAIL reset_cur: got %h want 0", bus.current_address); end
        n_total++; if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.fetch_err); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h0400_0000 + {16'h0, m_pc}, 1'b0, 1'b0, 16'h0);
            tick();
            n_total++;
            if (bus.ins_valid !== ((i % 2) == 0)) begin
                n_bad++; $display("FAIL seq_valid[%0d]: got %b want %b", i, bus.ins_valid, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                n_total++;
                if (bus.current_address !== 16'(i / 2) || bus.ins !== 32'h0400_0000 + 32'(i / 2) || bus.op !== 6'h01) begin
                    n_bad++; $display("FAIL seq_issue[%0d]: got cur=%h ins=%h op=%h want cur=%h ins=%h op=01",
                                      i, bus.current_address, bus.ins, bus.op, 16'(i / 2), 32'h0400_0000 + 32'(i / 2));
                end
            end else begin
                n_total++;
                if (bus.pm_req !== 1'b1 || bus.pm_addr !== 16'((i + 1) / 2)) begin
                    n_bad++; $display("FAIL seq_fetch[%0d]: got req=%b addr=%h want req=1 addr=%h",
                                      i, bus.pm_req, bus.pm_addr, 16'((i + 1) / 2));
                end
            end
        end
    endtask

    task automatic test_jump();
        do_reset();
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 32'h0400_0000 + 32'(a), 1'b0, 1'b0, 16'h0);
            tick();
            tick();
        end
        drive(1'b1, 32'h6000_0008, 1'b0, 1'b0, 16'h0);
        tick();
        n_total++;
        if (bus.op !== 6'h18 || bus.jmp_address_pm !== 16'h0008 || bus.current_address !== 16'h0003) begin
            n_bad++; $display("FAIL jump_issue: got op=%h jaddr=%h cur=%h want op=18 jaddr=0008 cur=0003",
                              bus.op, bus.jmp_address_pm, bus.current_address);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 16'h0008);
        tick();
        n_total++;
        if (bus.pm_req !== 1'b1 || bus.pm_addr !== 16'h0008) begin
            n_bad++; $display("FAIL jump_target: got req=%b addr=%h want req=1 addr=0008", bus.pm_req, bus.pm_addr);
        end
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 16'h0);
        tick();
        n_total++;
        if (bus.current_address !== 16'h0008 || bus.ins_valid !== 1'b1) begin
            n_bad++; $display("FAIL jump_next_cur: got cur=%h valid=%b want cur=0008 valid=1", bus.current_address, bus.ins_valid);
        end
    endtask

    // Runs right after test_jump: instruction 32'h1234_5678 from address 8 is being issued.
    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, $urandom, 1'b1, 1'b1, 16'($urandom));
            tick();
            n_total++;
            if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h1234_5678 || bus.current_address !== 16'h0008) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got valid=%b ins=%h cur=%h want valid=1 ins=12345678 cur=0008",
                                  c, bus.ins_valid, bus.ins, bus.current_address);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'hAAAA);
        tick();
        n_total++;
        if (bus.pm_req !== 1'b1 || bus.pm_addr !== 16'h0009) begin
            n_bad++; $display("FAIL stall_release: got req=%b addr=%h want req=1 addr=0009", bus.pm_req, bus.pm_addr);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 16'hFFFF);
        tick();
        drive(1'b1, 32'hFC00_FFFF, 1'b0, 1'b0, 16'h0);
        tick();
        n_total++;
        if (bus.current_address !== 16'hFFFF) begin
            n_bad++; $display("FAIL wrap_issue: got cur=%h want FFFF", bus.current_address);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h5555);
        tick();
        n_total++;
        if (bus.pm_addr !== 16'h0000 || bus.pm_req !== 1'b1 || bus.fetch_err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_next: got addr=%h req=%b err=%b want addr=0000 req=1 err=0",
                              bus.pm_addr, bus.pm_req, bus.fetch_err);
        end
    endtask

    // Runs right after test_wrap: a fresh fetch at address 0 has just begun.
    task automatic test_timeout();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        for (int c = 1; c <= 14; c++) tick();
        n_total++;
        if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got err=%b want 0 after 14 cycles", bus.fetch_err); end
        tick();
        n_total++;
        if (bus.fetch_err !== 1'b1 || bus.pm_addr !== 16'h0000 || bus.pm_req !== 1'b1) begin
            n_bad++; $display("FAIL timeout_flag: got err=%b addr=%h req=%b want err=1 addr=0000 req=1",
                              bus.fetch_err, bus.pm_addr, bus.pm_req);
        end
        drive(1'b1, 32'h0800_0042, 1'b0, 1'b0, 16'h0);
        tick();
        n_total++;
        if (bus.ins_valid !== 1'b1 || bus.ins !== 32'h0800_0042 || bus.fetch_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_late_ack: got valid=%b ins=%h err=%b want valid=1 ins=08000042 err=1",
                              bus.ins_valid, bus.ins, bus.fetch_err);
        end
        drive(1'b1, 32'h0, 1'b0, 1'b0, 16'h0);
        for (int c = 0; c < 6; c++) tick();
        n_total++;
        if (bus.fetch_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got err=%b want 1", bus.fetch_err); end
        do_reset();
        n_total++;
        if (bus.fetch_err !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got err=%b want 0", bus.fetch_err); end
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'h0400_0000, 1'b0, 1'b0, 16'h0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        tick();
        reset = 1'b1;
        drive(1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 16'h7777);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        n_total++;
        if (bus.ins !== 32'h0 || bus.ins_valid !== 1'b0 || bus.pm_addr !== RESET_PC || bus.pm_req !== 1'b1) begin
            n_bad++; $display("FAIL reset_midfetch: got ins=%h valid=%b addr=%h req=%b want ins=0 valid=0 addr=%h req=1",
                              bus.ins, bus.ins_valid, bus.pm_addr, bus.pm_req, RESET_PC);
        end
    endtask

    task automatic test_random();
        int ack_pct;
        logic [102:0] got, want;
        do_reset();
        ack_pct = 50;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ack_pct = 3;
                    1:       ack_pct = 50;
                    default: ack_pct = 90;
                endcase
            end
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < ack_pct, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 16'($urandom));
            tick();
            got  = {bus.pm_req, bus.ins_valid, bus.ins, bus.op, bus.jmp_address_pm, bus.current_address,
                    bus.fetch_err, (m_issue ? 16'h0 : bus.pm_addr)};
            want = {!m_issue, m_issue, m_ins, m_ins[31:26], m_ins[15:0], m_cur, m_err, (m_issue ? 16'h0 : m_pc)};
            n_total++;
            if (got !== want) begin
                n_bad++; $display("FAIL random[%0d]: got %h want %h", c, got, want);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 16'h0);
        m_issue = 1'b0; m_pc = RESET_PC; m_ins = '0; m_cur = '0; m_err = 1'b0; m_waited = 0;
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_wrap();
        test_timeout();
        test_reset_midfetch();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
